// File: rtl/sequence_counter_p.sv
// rtl/sequence_counter_p.sv - table-driven sequence counter with wrap pulse; optional backward stepping via SEQ_DOWN_EN
module sequence_counter_p #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [AW-1:0]    load_idx,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             last_we,
    input  logic [AW-1:0]    last_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic [AW-1:0]    idx,
    output logic             tc
);

    logic [WIDTH-1:0] tbl_q [DEPTH];
    logic [WIDTH-1:0] tbl_d [DEPTH];
    logic [AW-1:0]    idx_q, idx_d;
    logic [AW-1:0]    last_q, last_d;
    logic             tc_q, tc_d;
    logic             step_fwd;

`ifdef SEQ_DOWN_EN
    assign step_fwd = dir;
`else
    logic unused_dir;
    assign step_fwd   = 1'b1;
    assign unused_dir = dir;
`endif

    always_comb begin
        tbl_d = tbl_q;
        if (wr_en) begin
            tbl_d[wr_addr] = wr_data;
        end
        // A last write in the same edge already governs this edge's bound.
        last_d = last_we ? last_in : last_q;
        idx_d  = idx_q;
        tc_d   = 1'b0;
        if (load) begin
            idx_d = (load_idx > last_d) ? last_d : load_idx;
        end else if (en) begin
            if (step_fwd) begin
                if (idx_q < last_d) begin
                    idx_d = idx_q + 1'b1;
                end else begin
                    idx_d = '0;
                    tc_d  = 1'b1;
                end
            end else begin
                if (idx_q != '0) begin
                    idx_d = idx_q - 1'b1;
                end else begin
                    idx_d = last_d;
                    tc_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= WIDTH'(i);
            end
            idx_q  <= '0;
            last_q <= AW'(DEPTH - 1);
            tc_q   <= 1'b0;
        end else begin
            tbl_q  <= tbl_d;
            idx_q  <= idx_d;
            last_q <= last_d;
            tc_q   <= tc_d;
        end
    end

    assign q   = tbl_q[idx_q];
    assign qb  = ~q;
    assign idx = idx_q;
    assign tc  = tc_q;

endmodule

// File: doc/sequence_counter_p.md
SEQUENCE_COUNTER_P -- requirements
Module: sequence_counter_p

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, meaning the bit width of each sequence value.
REQ-002 The module SHALL have parameter DEPTH, default 8, meaning the number of table entries (power of two, >=2); AW = clog2(DEPTH) is derived and is not a port parameter.
REQ-003 The module SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock.
REQ-004 clr  in  1  asynchronous active-low clear.
REQ-005 en  in  1  step enable.
REQ-006 dir  in  1  1 = step forward through the table, 0 = step backward.
REQ-007 load  in  1  synchronous index load strobe; load_idx  in  AW  index to load.
REQ-008 wr_en  in  1  table write strobe; wr_addr  in  AW  entry address; wr_data  in  WIDTH  entry value.
REQ-009 last_we  in  1  active-length write strobe; last_in  in  AW  new last active index.
REQ-010 q  out  WIDTH  current sequence value; qb  out  WIDTH  bitwise inverse of q.
REQ-011 idx  out  AW  current table index; tc  out  1  terminal-count pulse.

Function
REQ-012 Internal state SHALL be table[0..DEPTH-1] (WIDTH each), idx register, last register (AW) and tc register, all updated on rising clk.
REQ-013 q SHALL equal table[idx] as held in registers after each edge; qb SHALL equal ~q at all times; no extra pipeline latency.
REQ-014 Per-edge priority: load over en; table write, last write and index update SHALL all take effect at the same edge.
REQ-015 load=1: idx <= min(load_idx, last_eff), where last_eff = last_in if last_we else last; tc <= 0.
REQ-016 load=0, en=1, dir=1: idx <= idx+1 if idx < last_eff; otherwise idx <= 0 and tc <= 1.
REQ-017 load=0, en=1, dir=0: idx <= idx-1 if idx > 0; at idx=0 idx <= last_eff and tc <= 1.
REQ-018 load=0, en=0: idx SHALL hold and tc <= 0.
REQ-019 tc SHALL be a single-cycle registered pulse, 1 only in the cycle after a wrap edge.
REQ-020 wr_en=1: table[wr_addr] <= wr_data; if wr_addr equals the new idx, q SHALL show wr_data after that edge.
REQ-021 If last is lowered below the current idx, the next forward step SHALL wrap to 0 with tc=1; a backward step SHALL decrement normally.
REQ-022 last=0 (single entry): every enabled step SHALL keep idx=0 and pulse tc.

Reset
REQ-023 clr=0 SHALL immediately, independent of clk, set idx=0, last=DEPTH-1, tc=0 and table[i]=i mod 2^WIDTH.
REQ-024 Reset outputs: q=0, qb=all ones, idx=0, tc=0.
REQ-025 Deassertion of clr SHALL be honoured at the first rising clk edge with clr=1; assertion mid-operation SHALL discard any pending step, load or write.

Configuration
REQ-026 Macro SEQ_DOWN_EN: when defined, dir SHALL behave per REQ-017; when undefined, the dir port SHALL remain present but be ignored and all steps SHALL be forward per REQ-016.

Verification
REQ-027 Reset, write table 0,13,11,9,6,12,3,15, en=1, dir=1 -> q = 0,13,11,9,6,12,3,15,0; tc=1 only in the cycle q returns to 0.
REQ-028 Same table, dir=0 from idx=0 -> q = 15,3,12,6,9,11,13,0 with tc=1 in the cycle q=15 (SEQ_DOWN_EN defined); undefined -> q = 13,11,...
REQ-029 last_we with last_in=3 while idx=5, en=1, dir=1 -> idx=0, tc=1 next cycle; load_idx=7 -> idx=3.
REQ-030 wr_en to wr_addr=idx+1 with en=1 -> q equals the newly written wr_data after that edge.
REQ-031 clr pulsed low between clk edges mid-count -> q=0, qb=4'hF, tc=0 immediately; table reads back i at each index.
